dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//   Shares the single-port data RAM between two requesters: port 0 (CPU load/store path)
//   and port 1 (program/data loader or debug port). Fair round-robin arbitration,
//   one outstanding transaction at a time, fixed read latency.
//   Sits between the requesters and the data RAM's Clock/addr/datain/write/read/dataout pins.
// PARAMETERS
//   AW      32  address width
//   DW      32  data width
//   RD_LAT  0   cycles after ISSUE until ram_dataout is valid; range 0..3
//               (0 = combinational-read RAM)
// PORTS
//   Clock       in   1   sole clock; all state updates on rising edge
//   Reset       in   1   asynchronous, active-high; clears all state immediately
//   req0/req1   in   1   request; held with we/addr/wdata stable until gnt
//   we0/we1     in   1   1 = write, 0 = read
//   addr0/1     in   AW  byte address
//   wdata0/1    in   DW  write data
//   gnt0/gnt1   out  1   one-cycle pulse; request accepted, driven on RAM this cycle
//   rvalid0/1   out  1   one-cycle pulse; rdataN valid (reads only)
//   rdata0/1    out  DW  captured read data; held until that port's next rvalid
//   ram_addr    out  AW  to RAM addr
//   ram_datain  out  DW  to RAM datain
//   ram_write   out  1   to RAM write
//   ram_read    out  1   to RAM read
//   ram_dataout in   DW  from RAM dataout
//   busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, last=1, every output 0 (rdata0/1=0). Any transaction in flight is
//     abandoned; no gnt or rvalid is produced for it.
//   States: IDLE, ISSUE, WAIT.
//   IDLE: on a clock edge with any reqN=1, latch port id, we, addr and wdata; go to ISSUE.
//     Both requesting: grant port != last. One requesting: grant it. None: stay IDLE.
//   ISSUE (one cycle): gntP=1; ram_addr/ram_datain from the latch;
//     ram_write=we, ram_read=~we; last <= P.
//     write -> IDLE.
//     read, RD_LAT=0 -> capture ram_dataout at the closing edge -> IDLE.
//     read, RD_LAT>0 -> WAIT with cnt=RD_LAT-1.
//   WAIT: ram_read=1, ram_addr held. cnt==0: capture ram_dataout -> IDLE;
//     otherwise cnt--.
//   rvalidP=1 for the single cycle after the capture edge, with rdataP=captured value.
//     This is the next IDLE cycle, so a new request can be latched in that same cycle.
//   Outside ISSUE/WAIT: ram_write=ram_read=0; ram_addr/ram_datain hold their last values.
//   Latency: write gnt 1 cycle after req sampled.
//     Read rvalid RD_LAT+2 cycles after req sampled.
//     Throughput: 1 write per 2 cycles; 1 read per RD_LAT+2 cycles.
//   req dropped before gnt: ignored if not yet latched. Once latched, the transaction
//     completes regardless of req.
//   req held after gnt: treated as a new request at the next IDLE.
//   No combinational path from req* to gnt*/ram_*; all outputs are registered or
//     decoded from state.
//   At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 high in any cycle.
// TESTING
//   1 RD_LAT=0: req0 write addr=0x10, wdata=0xDEADBEEF at cycle 0
//     -> gnt0 and ram_write in cycle 1 with ram_addr=0x10; busy=0 in cycle 2.
//   2 RD_LAT=0: req0 read 0x10 after test 1 -> ram_read in cycle 1;
//     rvalid0 in cycle 2 with rdata0=0xDEADBEEF.
//   3 req0 and req1 held high continuously, both writes, from reset
//     -> grant order 0,1,0,1; gnt every 2 cycles; never both high.
//   4 RD_LAT=2: req1 read -> ISSUE, 2 WAIT cycles with ram_addr stable;
//     rvalid1 4 cycles after req sampled; rvalid0 stays 0.
//   5 Reset asserted mid-WAIT -> all outputs 0 immediately; no rvalid afterwards.
//     A req0 after reset release is granted normally.
//   6 req1 pulsed one cycle while ISSUE serves port 0 -> never granted;
//     gnt1 stays 0.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data RAM.
// One transaction in flight at a time; reads complete after a fixed RAM latency.
module dram_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_datain,
  output logic          ram_write,
  output logic          ram_read,
  input  logic [DW-1:0] ram_dataout,
  output logic          busy
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sel;
  logic            capture;
  logic            gnt0_d, gnt1_d, ram_write_d, ram_read_d, busy_d;

  // RAM address/data come straight from the transaction latch, so they hold between transactions
  assign ram_addr   = addr_q;
  assign ram_datain = wdata_q;

  // Next-state, latch updates and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel     = (req0 && req1) ? ~last_q : req1;
          port_d  = sel;
          we_d    = sel ? we1 : we0;
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        last_d = port_q;
        if (we_q) begin
          state_d = IDLE;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt0_d      = (state_d == ISSUE) && !port_d;
    gnt1_d      = (state_d == ISSUE) && port_d;
    ram_write_d = (state_d == ISSUE) && we_d;
    ram_read_d  = ((state_d == ISSUE) && !we_d) || (state_d == WAIT);
    busy_d      = (state_d != IDLE);
  end

  // State, transaction latch and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ram_write <= 1'b0;
      ram_read  <= 1'b0;
      busy      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      ram_write <= ram_write_d;
      ram_read  <= ram_read_d;
      busy      <= busy_d;
      rvalid0   <= capture && !port_q;
      rvalid1   <= capture && port_q;
      if (capture && !port_q) rdata0 <= ram_dataout;
      if (capture && port_q)  rdata1 <= ram_dataout;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench: one arbiter with a combinational-read RAM (a_*), one with RD_LAT=2 (b_*).
module tb_dram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;

  logic          a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_ram_write, a_ram_read, a_busy;
  logic [DW-1:0] a_rdata0, a_rdata1, a_ram_datain, a_ram_dataout;
  logic [AW-1:0] a_ram_addr;
  logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_ram_write, b_ram_read, b_busy;
  logic [DW-1:0] b_rdata0, b_rdata1, b_ram_datain, b_ram_dataout;
  logic [AW-1:0] b_ram_addr;

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(0)) u_a (
    .Clock(Clock), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata0(a_rdata0), .rdata1(a_rdata1),
    .ram_addr(a_ram_addr), .ram_datain(a_ram_datain),
    .ram_write(a_ram_write), .ram_read(a_ram_read),
    .ram_dataout(a_ram_dataout), .busy(a_busy)
  );

  dram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) u_b (
    .Clock(Clock), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1),
    .ram_addr(b_ram_addr), .ram_datain(b_ram_datain),
    .ram_write(b_ram_write), .ram_read(b_ram_read),
    .ram_dataout(b_ram_dataout), .busy(b_busy)
  );

  // Word-addressed RAM models; read data follows the held address
  assign a_ram_dataout = mem_a[a_ram_addr[5:2]];
  assign b_ram_dataout = mem_b[b_ram_addr[5:2]];

  always @(posedge Clock) begin
    if (a_ram_write) mem_a[a_ram_addr[5:2]] <= a_ram_datain;
    if (b_ram_write) mem_b[b_ram_addr[5:2]] <= b_ram_datain;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  logic [1:0] exp_gnt [8];
  logic       seen;

  initial begin
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b00; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b00;
    exp_gnt[4] = 2'b01; exp_gnt[5] = 2'b00; exp_gnt[6] = 2'b10; exp_gnt[7] = 2'b00;

    step();
    Reset = 1'b0;
    check("reset_outputs", 64'({a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_ram_write, a_ram_read, a_busy}), 64'd0);
    check("reset_rdata0", 64'(a_rdata0), 64'd0);

    // Test 1: write 0xDEADBEEF to 0x10 from port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    step();
    check("t1_gnt0", 64'(a_gnt0), 64'd1);
    check("t1_ram_write", 64'(a_ram_write), 64'd1);
    check("t1_ram_addr", 64'(a_ram_addr), 64'h10);
    check("t1_ram_datain", 64'(a_ram_datain), 64'hDEADBEEF);
    req0 = 1'b0;
    step();
    check("t1_busy_clear", 64'(a_busy), 64'd0);

    // Test 2: read it back, rvalid the cycle after ISSUE
    req0 = 1'b1; we0 = 1'b0;
    step();
    check("t2_ram_read", 64'({a_gnt0, a_ram_read, a_ram_write}), 64'b110);
    req0 = 1'b0;
    step();
    check("t2_rvalid0", 64'({a_rvalid0, a_rvalid1}), 64'b10);
    check("t2_rdata0", 64'(a_rdata0), 64'hDEADBEEF);

    // Test 3: both ports hold write requests; alternating grants every 2 cycles
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t3_gnt_c%0d", i + 1), 64'({a_gnt1, a_gnt0}), 64'(exp_gnt[i]));
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Test 4: RD_LAT=2, port 1 writes then reads 0x20
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hCAFEF00D;
    step();
    req1 = 1'b0;
    step();
    req1 = 1'b1; we1 = 1'b0;
    step();
    check("t4_issue", 64'({b_gnt1, b_ram_read, b_busy}), 64'b111);
    check("t4_issue_addr", 64'(b_ram_addr), 64'h20);
    req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("t4_wait%0d", i), 64'({b_gnt1, b_ram_read, b_busy, b_rvalid1}), 64'b0110);
      check($sformatf("t4_wait%0d_addr", i), 64'(b_ram_addr), 64'h20);
    end
    step();
    check("t4_rvalid", 64'({b_rvalid1, b_rvalid0, b_busy}), 64'b100);
    check("t4_rdata1", 64'(b_rdata1), 64'hCAFEF00D);

    // Test 5: reset during WAIT abandons the read
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    step();
    req0 = 1'b0;
    step();
    Reset = 1'b1;
    #1;
    check("t5_reset_ctrl", 64'({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_ram_write, b_ram_read, b_busy}), 64'd0);
    check("t5_reset_addr", 64'(b_ram_addr), 64'd0);
    check("t5_reset_rdata1", 64'(b_rdata1), 64'd0);
    step();
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | b_rvalid0 | b_rvalid1 | b_busy;
    end
    check("t5_no_rvalid", 64'(seen), 64'd0);
    req0 = 1'b1;
    step();
    check("t5_regrant", 64'(b_gnt0), 64'd1);
    req0 = 1'b0;
    step();
    step();
    step();
    check("t5_rvalid0", 64'(b_rvalid0), 64'd1);
    check("t5_rdata0", 64'(b_rdata0), 64'hCAFEF00D);

    // Test 6: a one-cycle req1 pulse during port 0's ISSUE is never latched
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h1234;
    step();
    check("t6_gnt0", 64'(a_gnt0), 64'd1);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h3C;
    step();
    req1 = 1'b0;
    seen = a_gnt1 | a_busy;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | a_gnt1 | a_busy;
    end
    check("t6_no_gnt1", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
